// File: rtl/fx_gate_sender.sv
`timescale 1ns/1ps
// Measured-clock gate sequencer: opens a window of gate_time_i clk_fx cycles, counts them,
// and hands the count to the clk_fs receiver over a 4-phase req/ack handshake.
module fx_gate_sender #(
  parameter int unsigned CNT_W       = 30,
  parameter int unsigned PRE_CYCLES  = 10,
  parameter int unsigned POST_CYCLES = 10,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic             clk_fx,
  input  logic             rst_n,
  input  logic             meas_en,
  input  logic [15:0]      gate_time_i,
  input  logic             ack_in,
  output logic             gate,
  output logic             req,
  output logic [CNT_W-1:0] fx_count,
  output logic [7:0]       meas_id,
  output logic             busy,
  output logic             ack_err
);

  localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned TMR_W = (TO_W > 16) ? TO_W : 16;

  localparam logic [TMR_W-1:0] PRE_LAST  = TMR_W'(PRE_CYCLES - 1);
  localparam logic [TMR_W-1:0] POST_LAST = TMR_W'(POST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_OPEN = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_REQ  = 3'd4;
  localparam logic [2:0] S_REL  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [15:0]      win_len_q, win_len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_q, gate_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] fx_q, fx_d;
  logic [7:0]       id_q, id_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             ack_m_q, ack_s_q;
  logic [15:0]      win_sel_c;

  // A zero window length is promoted to one cycle so every measurement has a gate pulse.
  assign win_sel_c = (gate_time_i == 16'd0) ? 16'd1 : gate_time_i;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    win_len_d = win_len_q;
    cnt_d     = cnt_q;
    gate_d    = gate_q;
    req_d     = req_q;
    fx_d      = fx_q;
    id_d      = id_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (meas_en) begin
          state_d   = S_PRE;
          win_len_d = win_sel_c;
          cnt_d     = '0;
          tmr_d     = '0;
        end
      end
      S_PRE: begin
        if (tmr_q == PRE_LAST) begin
          state_d = S_OPEN;
          gate_d  = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_OPEN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (tmr_q == TMR_W'(win_len_q - 16'd1)) begin
          state_d = S_POST;
          gate_d  = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_POST: begin
        if (tmr_q == POST_LAST) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          fx_d    = cnt_q;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_REQ: begin
        if (ack_s_q) begin
          state_d = S_REL;
          req_d   = 1'b0;
          id_d    = id_q + 8'd1;
          tmr_d   = '0;
        end else if (tmr_q == TO_LAST) begin
          state_d = S_REL;
          req_d   = 1'b0;
          err_d   = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_REL: begin
        // A stuck-high ack is abandoned after the timeout so the meter keeps running.
        if (!ack_s_q || (tmr_q == TO_LAST)) begin
          if (ack_s_q) begin
            err_d = 1'b1;
          end
          tmr_d = '0;
          if (meas_en) begin
            state_d   = S_PRE;
            win_len_d = win_sel_c;
            cnt_d     = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gate_d  = 1'b0;
        req_d   = 1'b0;
        tmr_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, plus the 2-flop ack synchronizer.
  always_ff @(posedge clk_fx or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      win_len_q <= 16'd1;
      cnt_q     <= '0;
      gate_q    <= 1'b0;
      req_q     <= 1'b0;
      fx_q      <= '0;
      id_q      <= 8'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_m_q   <= 1'b0;
      ack_s_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      win_len_q <= win_len_d;
      cnt_q     <= cnt_d;
      gate_q    <= gate_d;
      req_q     <= req_d;
      fx_q      <= fx_d;
      id_q      <= id_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ack_m_q   <= ack_in;
      ack_s_q   <= ack_m_q;
    end
  end

  assign gate     = gate_q;
  assign req      = req_q;
  assign fx_count = fx_q;
  assign meas_id  = id_q;
  assign busy     = busy_q;
  assign ack_err  = err_q;

endmodule

// File: tb/tb_fx_gate_sender.sv
`timescale 1ns/1ps
// Bench for fx_gate_sender: timestamp-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized stretch.
module tb_fx_gate_sender;

  localparam int unsigned CNT_W = 30;
  localparam longint      PRE   = 10;
  localparam longint      POST  = 10;
  localparam longint      TO    = 4096;

  logic             clk_fx;
  logic             rst_n;
  logic             meas_en;
  logic [15:0]      gate_time_i;
  logic             ack_in;
  logic             gate;
  logic             req;
  logic [CNT_W-1:0] fx_count;
  logic [7:0]       meas_id;
  logic             busy;
  logic             ack_err;

  fx_gate_sender #(
    .CNT_W(CNT_W), .PRE_CYCLES(10), .POST_CYCLES(10), .ACK_TIMEOUT(4096)
  ) dut (
    .clk_fx(clk_fx), .rst_n(rst_n), .meas_en(meas_en), .gate_time_i(gate_time_i),
    .ack_in(ack_in), .gate(gate), .req(req), .fx_count(fx_count), .meas_id(meas_id),
    .busy(busy), .ack_err(ack_err)
  );

  int checks;
  int errors;

  initial begin
    clk_fx = 1'b0;
    forever #5 clk_fx = ~clk_fx;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each measurement is a set of absolute edge timestamps.
  longint      e;
  bit          active;
  longint      t_rise, t_fall, t_req, t_rel;
  longint      m_len;
  bit          m_gate, m_req, m_busy, m_err;
  longint      m_fx, m_id;
  bit          h1, h2;

  function automatic void model_clear();
    active = 0; m_gate = 0; m_req = 0; m_busy = 0; m_err = 0;
    m_fx = 0; m_id = 0; h1 = 0; h2 = 0; t_rel = -1;
    t_rise = -1; t_fall = -1; t_req = -1;
  endfunction

  function automatic void model_start(input longint at);
    active = 1;
    if (gate_time_i == 16'd0) m_len = 1;
    else m_len = longint'(gate_time_i);
    t_rise = at + PRE;
    t_fall = t_rise + m_len;
    t_req  = t_fall + POST;
    t_rel  = -1;
  endfunction

  initial begin
    model_clear();
    e = 0;
    forever begin
      @(posedge clk_fx or negedge rst_n);
      if (!rst_n) begin
        model_clear();
      end else begin : step
        bit ack_s;
        ack_s = h2;
        h2 = h1;
        h1 = ack_in;
        e++;
        if (!active) begin
          if (meas_en) model_start(e);
        end else begin
          if (e == t_rise) m_gate = 1;
          if (e == t_fall) m_gate = 0;
          if (e == t_req) begin
            m_req = 1;
            m_fx  = (m_len > 64'h3FFF_FFFF) ? 64'h3FFF_FFFF : m_len;
          end else if (t_rel < 0 && e > t_req) begin
            if (ack_s) begin
              m_req = 0; m_id = (m_id + 1) % 256; t_rel = e;
            end else if (e - t_req == TO) begin
              m_req = 0; m_err = 1; t_rel = e;
            end
          end else if (t_rel >= 0 && e > t_rel) begin
            if (!ack_s || (e - t_rel == TO)) begin
              if (ack_s) m_err = 1;
              if (meas_en) model_start(e);
              else active = 0;
            end
          end
        end
        m_busy = active;
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk_fx);
      check("gate",     64'(gate),     64'(m_gate));
      check("req",      64'(req),      64'(m_req));
      check("busy",     64'(busy),     64'(m_busy));
      check("ack_err",  64'(ack_err),  64'(m_err));
      check("fx_count", 64'(fx_count), 64'(m_fx));
      check("meas_id",  64'(meas_id),  64'(m_id));
    end
  end

  // Acknowledge responder with programmable delays.
  bit resp_en;
  int ack_dly, rel_dly, rcnt;
  initial begin
    ack_in = 1'b0;
    rcnt = 0;
    forever begin
      @(posedge clk_fx);
      #2;
      if (!resp_en) begin
        ack_in = 1'b0; rcnt = 0;
      end else if (req && !ack_in) begin
        rcnt++;
        if (rcnt >= ack_dly) begin ack_in = 1'b1; rcnt = 0; end
      end else if (!req && ack_in) begin
        rcnt++;
        if (rcnt >= rel_dly) begin ack_in = 1'b0; rcnt = 0; end
      end else begin
        rcnt = 0;
      end
    end
  end

  function automatic logic cur(input int sel);
    case (sel)
      0:       return gate;
      1:       return req;
      default: return busy;
    endcase
  endfunction

  // Counts edges until the selected output reaches v; an expired bound is a failure.
  task automatic wait_out(input int sel, input logic v, input int lim, output int n);
    n = 0;
    while (cur(sel) !== v && n < lim) begin
      @(posedge clk_fx);
      #1;
      n++;
    end
    if (cur(sel) !== v) check($sformatf("wait_sel%0d", sel), 64'(cur(sel)), 64'(v));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=%0d required=%0d", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  int n;
  int prev_id;
  bit saw_wrap;

  initial begin
    checks = 0; errors = 0;
    resp_en = 1; ack_dly = 3; rel_dly = 2;
    rst_n = 1'b1; meas_en = 1'b1; gate_time_i = 16'd2000;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk_fx);
    #1;
    check("rst_gate", 64'(gate), 64'd0);
    check("rst_req", 64'(req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(ack_err), 64'd0);
    check("rst_fx", 64'(fx_count), 64'd0);
    check("rst_id", 64'(meas_id), 64'd0);
    meas_en = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_fx);
    #1;

    // Single 2000-cycle window.
    meas_en = 1'b1;
    wait_out(0, 1'b1, 100, n);
    check("rise_delay", 64'(n), 64'd11);
    meas_en = 1'b0;
    wait_out(0, 1'b0, 5000, n);
    check("gate_width", 64'(n), 64'd2000);
    wait_out(1, 1'b1, 100, n);
    check("req_delay", 64'(n), 64'd10);
    check("fx_2000", 64'(fx_count), 64'd2000);
    wait_out(1, 1'b0, 100, n);
    check("id_after_ack", 64'(meas_id), 64'd1);
    wait_out(2, 1'b0, 100, n);

    // Zero length, then a change during OPEN that must only affect the next window.
    gate_time_i = 16'd0;
    meas_en = 1'b1;
    wait_out(0, 1'b1, 100, n);
    wait_out(0, 1'b0, 10, n);
    check("zero_width", 64'(n), 64'd1);
    wait_out(1, 1'b1, 100, n);
    check("fx_zero", 64'(fx_count), 64'd1);
    gate_time_i = 16'd100;
    wait_out(1, 1'b0, 100, n);
    wait_out(0, 1'b1, 100, n);
    gate_time_i = 16'd7;
    wait_out(1, 1'b1, 300, n);
    check("fx_latched100", 64'(fx_count), 64'd100);
    wait_out(1, 1'b0, 100, n);
    wait_out(1, 1'b1, 300, n);
    check("fx_next7", 64'(fx_count), 64'd7);
    gate_time_i = 16'd50;

    // Continuous run long enough to wrap meas_id.
    prev_id = int'(meas_id);
    saw_wrap = 0;
    for (int i = 0; i < 300; i++) begin
      ack_dly = int'($urandom_range(1, 6));
      rel_dly = int'($urandom_range(1, 6));
      wait_out(1, 1'b0, 200, n);
      wait_out(1, 1'b1, 300, n);
      check("fx_cont50", 64'(fx_count), 64'd50);
      check("id_seq", 64'(meas_id), 64'((prev_id + 1) % 256));
      if (prev_id == 255 && meas_id == 8'd0) saw_wrap = 1;
      prev_id = int'(meas_id);
    end
    check("id_wrapped", 64'(saw_wrap), 64'd1);

    // Stuck-low ack: timeout, sticky error, meter keeps going.
    wait_out(1, 1'b0, 200, n);
    resp_en = 0;
    wait_out(1, 1'b1, 300, n);
    wait_out(1, 1'b0, 5000, n);
    check("timeout_len", 64'(n), 64'd4096);
    check("err_set", 64'(ack_err), 64'd1);
    resp_en = 1;
    wait_out(1, 1'b1, 300, n);
    check("fx_after_to", 64'(fx_count), 64'd50);
    wait_out(1, 1'b0, 200, n);

    // Randomized enable, window length and responder timing.
    for (int i = 0; i < 40; i++) begin
      gate_time_i = 16'($urandom_range(0, 60));
      meas_en = ($urandom_range(0, 3) != 0);
      ack_dly = int'($urandom_range(1, 8));
      rel_dly = int'($urandom_range(1, 8));
      repeat ($urandom_range(20, 150)) @(posedge clk_fx);
      #1;
    end

    // Reset in the middle of an open window.
    gate_time_i = 16'd300;
    meas_en = 1'b1;
    ack_dly = 2;
    wait_out(0, 1'b1, 3000, n);
    rst_n = 1'b0;
    #1;
    check("async_gate", 64'(gate), 64'd0);
    check("async_fx", 64'(fx_count), 64'd0);
    repeat (2) @(posedge clk_fx);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_fx);
    #1;
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_fx", 64'(fx_count), 64'd0);
    wait_out(1, 1'b1, 1000, n);
    check("fx_restart300", 64'(fx_count), 64'd300);
    meas_en = 1'b0;
    wait_out(2, 1'b0, 200, n);
    repeat (2) @(posedge clk_fx);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
